// File: rtl/oc8051_cxrom_fetch_if.sv
// Core/ROM bus bundle for the cxrom fetch unit.
// master drives requests and ROM data; slave is the fetch unit.
interface oc8051_cxrom_fetch_if;
  logic        req;
  logic [15:0] req_addr;
  logic        ack;
  logic [31:0] word_out;
  logic [15:0] cxrom_addr;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic        rom_rdy;
  logic [7:0]  rom_data;

  modport master (
    output req, req_addr, rom_rdy, rom_data,
    input  ack, word_out, cxrom_addr, rom_rd, rom_addr
  );

  modport slave (
    input  req, req_addr, rom_rdy, rom_data,
    output ack, word_out, cxrom_addr, rom_rd, rom_addr
  );
endinterface

// File: rtl/oc8051_cxrom_fetch.sv
// Assembles a 4-byte code window from a byte-wide ROM.
// OC8051_CXROM_FETCH_HIT_EN adds a one-entry last-base hit tag.
module oc8051_cxrom_fetch (
  input logic                 clk,
  input logic                 rst,
  oc8051_cxrom_fetch_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  k;
  logic [15:0] base;
  logic [31:0] word;
  logic        hit;
  logic        last;

  assign last = (state == READ) && bus.rom_rdy && (k == 2'd3);

`ifdef OC8051_CXROM_FETCH_HIT_EN
  logic [15:0] tag;
  logic        tag_vld;

  assign hit = tag_vld && (bus.req_addr == tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag     <= 16'h0;
      tag_vld <= 1'b0;
    end else if (last) begin
      tag     <= base;
      tag_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.req) state_nx = hit ? DONE : READ;
      end
      READ: begin
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k    <= 2'd0;
      base <= 16'h0;
      word <= 32'h0;
    end else begin
      if (state == IDLE && bus.req) begin
        base <= bus.req_addr;
        k    <= 2'd0;
      end
      if (state == READ && bus.rom_rdy) begin
        word[{k, 3'b000} +: 8] <= bus.rom_data;
        k <= k + 2'd1;
      end
    end
  end

  // k wraps to 0 after byte 3, so rom_addr rests on base outside READ
  assign bus.rom_addr   = base + {14'h0, k};
  assign bus.rom_rd     = (state == READ);
  assign bus.ack        = (state == DONE);
  assign bus.word_out   = word;
  assign bus.cxrom_addr = base;
endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Directed bench for oc8051_cxrom_fetch.
// Honours OC8051_CXROM_FETCH_HIT_EN for the repeat-address case.
module tb_oc8051_cxrom_fetch;
  logic clk = 1'b0;
  logic rst;

  oc8051_cxrom_fetch_if bus ();

  oc8051_cxrom_fetch dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_cyc;
  int nrd;
  logic [15:0] seq [16];

  // ROM image: hand-loaded bytes at 0010..0013, else addr ^ 5A
  function automatic logic [7:0] rb(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h02;
      16'h0011: return 8'h00;
      16'h0012: return 8'h30;
      16'h0013: return 8'hE4;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign bus.rom_data = rb(bus.rom_addr);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(
    input logic [15:0] a,
    input int          stall,
    input bit          glitch,
    input bit          hold
  );
    int left;
    bit done;
    left    = stall;
    done    = 1'b0;
    nrd     = 0;
    ack_cyc = 0;
    bus.req      = 1'b1;
    bus.req_addr = a;
    @(posedge clk);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      chk("rd_ack_excl", {31'h0, bus.rom_rd & bus.ack}, 32'h0);
      if (bus.rom_rd) begin
        if (nrd < 16) seq[nrd] = bus.rom_addr;
        nrd++;
      end
      if (bus.ack) begin
        ack_cyc = c;
        done    = 1'b1;
      end
      bus.rom_rdy = !(left > 0 && bus.rom_rd &&
                      bus.rom_addr == a + 16'd1);
      if (!bus.rom_rdy) left--;
      if (glitch && c == 2) bus.req_addr = 16'hBEEF;
    end
    if (!done) begin
      chk("ack_timeout", 32'h0, 32'h1);
    end else begin
      if (!hold) bus.req = 1'b0;
      @(negedge clk);
      chk("ack_pulse", {31'h0, bus.ack}, 32'h0);
    end
    bus.rom_rdy = 1'b1;
  endtask

  initial begin
    int n1;
    rst          = 1'b1;
    bus.req      = 1'b0;
    bus.req_addr = 16'h0;
    bus.rom_rdy  = 1'b1;
    #1;
    chk("rst_ack", {31'h0, bus.ack}, 32'h0);
    chk("rst_rd", {31'h0, bus.rom_rd}, 32'h0);
    chk("rst_word", bus.word_out, 32'h0);
    chk("rst_cx", {16'h0, bus.cxrom_addr}, 32'h0);
    chk("rst_raddr", {16'h0, bus.rom_addr}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rd", {31'h0, bus.rom_rd}, 32'h0);
      chk("idle_ack", {31'h0, bus.ack}, 32'h0);
    end

    // basic fetch
    fetch(16'h0010, 0, 1'b0, 1'b0);
    chk("b_ack_cyc", ack_cyc, 5);
    chk("b_nrd", nrd, 4);
    chk("b_a0", {16'h0, seq[0]}, 32'h0010);
    chk("b_a1", {16'h0, seq[1]}, 32'h0011);
    chk("b_a2", {16'h0, seq[2]}, 32'h0012);
    chk("b_a3", {16'h0, seq[3]}, 32'h0013);
    chk("b_word", bus.word_out, 32'hE4300002);
    chk("b_cx", {16'h0, bus.cxrom_addr}, 32'h0010);

    // repeat of the last acked base
    fetch(16'h0010, 0, 1'b0, 1'b0);
`ifdef OC8051_CXROM_FETCH_HIT_EN
    chk("h_ack_cyc", ack_cyc, 1);
    chk("h_nrd", nrd, 0);
`else
    chk("h_ack_cyc", ack_cyc, 5);
    chk("h_nrd", nrd, 4);
`endif
    chk("h_word", bus.word_out, 32'hE4300002);
    chk("h_cx", {16'h0, bus.cxrom_addr}, 32'h0010);

    // address wrap
    fetch(16'hFFFE, 0, 1'b0, 1'b0);
    chk("w_nrd", nrd, 4);
    chk("w_a0", {16'h0, seq[0]}, 32'hFFFE);
    chk("w_a1", {16'h0, seq[1]}, 32'hFFFF);
    chk("w_a2", {16'h0, seq[2]}, 32'h0000);
    chk("w_a3", {16'h0, seq[3]}, 32'h0001);
    chk("w_word", bus.word_out, 32'h5B5AA5A4);
    chk("w_cx", {16'h0, bus.cxrom_addr}, 32'hFFFE);

    // 3-cycle stall on byte 1
    fetch(16'h0020, 3, 1'b0, 1'b0);
    chk("s_ack_cyc", ack_cyc, 8);
    chk("s_nrd", nrd, 7);
    n1 = 0;
    for (int i = 0; i < 7; i++)
      if (seq[i] == 16'h0021) n1++;
    chk("s_hold_a1", n1, 4);
    chk("s_word", bus.word_out, 32'h79787B7A);

    // req_addr disturbed mid-READ is ignored
    fetch(16'h0030, 0, 1'b1, 1'b0);
    chk("g_ack_cyc", ack_cyc, 5);
    chk("g_a3", {16'h0, seq[3]}, 32'h0033);
    chk("g_cx", {16'h0, bus.cxrom_addr}, 32'h0030);
    chk("g_word", bus.word_out, 32'h69686B6A);

    // back-to-back with req held high
    fetch(16'h0040, 0, 1'b0, 1'b1);
    chk("bb1_word", bus.word_out, 32'h19181B1A);
    fetch(16'h0050, 0, 1'b0, 1'b0);
    chk("bb2_ack_cyc", ack_cyc, 5);
    chk("bb2_a0", {16'h0, seq[0]}, 32'h0050);
    chk("bb2_word", bus.word_out, 32'h09080B0A);

    // async reset mid-READ
    bus.req      = 1'b1;
    bus.req_addr = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("r_pre_rd", {31'h0, bus.rom_rd}, 32'h1);
    chk("r_pre_b0", {24'h0, bus.word_out[7:0]}, 32'h5A);
    rst = 1'b1;
    #1;
    chk("r_rd", {31'h0, bus.rom_rd}, 32'h0);
    chk("r_word", bus.word_out, 32'h0);
    chk("r_ack", {31'h0, bus.ack}, 32'h0);
    chk("r_raddr", {16'h0, bus.rom_addr}, 32'h0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("r_no_ack", {31'h0, bus.ack}, 32'h0);
      chk("r_no_rd", {31'h0, bus.rom_rd}, 32'h0);
    end
    fetch(16'h0010, 0, 1'b0, 1'b0);
    chk("rf_ack_cyc", ack_cyc, 5);
    chk("rf_nrd", nrd, 4);
    chk("rf_a0", {16'h0, seq[0]}, 32'h0010);
    chk("rf_word", bus.word_out, 32'hE4300002);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
